memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 28 ++
 rtl/sync_ram_8bit.sv | 26 ++
 rtl/memory_responder.sv | 134 +++++++++++++
 tb/tb_memory_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and default parameters for the memory responder.
package memory_responder_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_BASE_DEFAULT   = 16'h0000;
  localparam int unsigned       DEPTH_LOG2_DEFAULT  = 10;
  localparam int unsigned       WAIT_STATES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Offset from the window base (mod 2**16) must fall below the window size.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       depth_log2);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (32'(off) < (32'd1 << depth_log2));
  endfunction

endpackage

// File: rtl/sync_ram_8bit.sv
// Single-port byte array: synchronous write, registered read, no reset.
module sync_ram_8bit
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read share the one address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-mapped byte responder on a shared tri-state processor data bus.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned       DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
  parameter int unsigned       WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_t                  state, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_next;
  logic                    accept_c;

  logic                    is_read_q;
  logic                    in_win_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    drive_q;

  logic [ADDR_W-1:0]       offset_c;
  logic                    live_in_win_c;
  logic                    sel_read_c;
  logic                    sel_in_win_c;
  logic [DEPTH_LOG2-1:0]   ram_addr_c;
  logic                    ram_we_c;
  logic [DATA_W-1:0]       ram_rdata;

  // Window decode of the live address; used only at the acceptance edge.
  assign offset_c      = address - ADDR_BASE;
  assign live_in_win_c = in_window(address, ADDR_BASE, DEPTH_LOG2);

  // Transaction attributes: live at acceptance, captured copies afterwards.
  assign sel_read_c   = accept_c ? mem_read : is_read_q;
  assign sel_in_win_c = accept_c ? live_in_win_c : in_win_q;

  // Array is read at acceptance with the live index so zero-wait reads have data.
  assign ram_addr_c = (state == IDLE) ? offset_c[DEPTH_LOG2-1:0] : idx_q;
  assign ram_we_c   = (state == RESPOND) && !is_read_q && in_win_q;

  // Bus driven only during an in-window read response.
  assign data_bus = drive_q ? ram_rdata : {DATA_W{1'bz}};

  sync_ram_8bit #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    accept_c      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          accept_c      = 1'b1;
          state_next    = (WAIT_STATES == 0) ? RESPOND : WAIT;
          wait_cnt_next = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_next = RESPOND;
        end else begin
          wait_cnt_next = wait_cnt - WAIT_CNT_W'(1);
        end
      end
      RESPOND: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!mem_read && !mem_write) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      busy      <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_ready <= (state_next == RESPOND);
      mem_error <= (state_next == RESPOND) && !sel_in_win_c;
      busy      <= (state_next != IDLE);
      drive_q   <= (state_next == RESPOND) && sel_read_c && sel_in_win_c;
    end
  end

  // Request capture at acceptance, immune to later bus/address activity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_read_q <= 1'b0;
      in_win_q  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else if (accept_c) begin
      is_read_q <= mem_read;
      in_win_q  <= live_in_win_c;
      idx_q     <= offset_c[DEPTH_LOG2-1:0];
      wdata_q   <= data_bus;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench: two responders (default window / zero-wait wrapped window) on common requests.
module tb_memory_responder;
  import memory_responder_pkg::*;

  // Undriven bus lines are pulled up, so a released bus reads all ones.
  localparam logic [7:0] FLOAT = 8'hFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read, mem_write;
  logic [15:0] address;
  logic        tb_drv;
  logic [7:0]  tb_val;

  wire  [7:0]  bus_a, bus_b;
  wire         rdy_a, err_a, busy_a, rdy_b, err_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  assign bus_a = tb_drv ? tb_val : 8'hzz;
  assign bus_b = tb_drv ? tb_val : 8'hzz;
  pullup (bus_a[0]); pullup (bus_a[1]); pullup (bus_a[2]); pullup (bus_a[3]);
  pullup (bus_a[4]); pullup (bus_a[5]); pullup (bus_a[6]); pullup (bus_a[7]);
  pullup (bus_b[0]); pullup (bus_b[1]); pullup (bus_b[2]); pullup (bus_b[3]);
  pullup (bus_b[4]); pullup (bus_b[5]); pullup (bus_b[6]); pullup (bus_b[7]);

  memory_responder #(.ADDR_BASE(16'h0000), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_bus(bus_a), .mem_ready(rdy_a), .mem_error(err_a), .busy(busy_a));

  memory_responder #(.ADDR_BASE(16'hFE00), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_bus(bus_b), .mem_ready(rdy_b), .mem_error(err_b), .busy(busy_b));

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          lat_m  [2] = '{2, 0};
  logic [15:0] base_m [2] = '{16'h0000, 16'hFE00};
  int          cyc = 0;
  bit          m_busy [2];
  int          m_resp [2];
  bit          m_read [2];
  bit          m_win  [2];
  int          m_idx  [2];
  logic [7:0]  m_wd   [2];
  logic [7:0]  m_mem  [2][1024];
  bit          m_known[2][1024];
  bit          e_rdy[2], e_err[2], e_busy[2], e_drv[2], e_known[2];
  logic [7:0]  e_data[2];

  // Transaction timeline: accept, respond lat edges later, write lands one edge later,
  // idle at the first later edge that sees both request lines low.
  always @(posedge clock) begin
    if (reset) begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          if (mem_read != mem_write) begin
            int off;
            off       = (int'(address) - int'(base_m[k]) + 65536) % 65536;
            m_busy[k] = 1'b1;
            m_resp[k] = cyc + lat_m[k];
            m_read[k] = mem_read;
            m_win[k]  = (off < 1024);
            m_idx[k]  = off % 1024;
            m_wd[k]   = tb_drv ? tb_val : FLOAT;
          end
        end else if (cyc == m_resp[k] + 1) begin
          if (!m_read[k] && m_win[k]) begin
            m_mem[k][m_idx[k]]   = m_wd[k];
            m_known[k][m_idx[k]] = 1'b1;
          end
        end else if (cyc >= m_resp[k] + 2 && !mem_read && !mem_write) begin
          m_busy[k] = 1'b0;
        end
        e_busy[k]  = m_busy[k];
        e_rdy[k]   = m_busy[k] && (cyc == m_resp[k]);
        e_err[k]   = e_rdy[k] && !m_win[k];
        e_drv[k]   = e_rdy[k] && m_read[k] && m_win[k];
        e_data[k]  = m_mem[k][m_idx[k]];
        e_known[k] = m_known[k][m_idx[k]];
      end
    end
  end

  // Reset abandons any transaction in flight.
  always @(negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; e_busy[k] = 1'b0; e_rdy[k] = 1'b0;
      e_err[k] = 1'b0;  e_drv[k] = 1'b0;
    end
  end

  // Per-cycle comparison of both responders against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] b;
        b = (k == 0) ? bus_a : bus_b;
        chk1($sformatf("cmp_ready[%0d]", k), (k == 0) ? rdy_a : rdy_b, e_rdy[k]);
        chk1($sformatf("cmp_error[%0d]", k), (k == 0) ? err_a : err_b, e_err[k]);
        chk1($sformatf("cmp_busy[%0d]", k), (k == 0) ? busy_a : busy_b, e_busy[k]);
        if (tb_drv) begin
          chk8($sformatf("cmp_bus_contend[%0d]", k), b, tb_val);
        end else if (e_drv[k]) begin
          if (e_known[k]) chk8($sformatf("cmp_bus_data[%0d]", k), b, e_data[k]);
          else chk1($sformatf("cmp_bus_known[%0d]", k), $isunknown(b), 1'b0);
        end else begin
          chk8($sformatf("cmp_bus_float[%0d]", k), b, FLOAT);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    mem_read = r; mem_write = w; address = a; tb_val = d; tb_drv = w;
  endtask

  // One complete transaction with literal timing/data expectations; starts and ends off-edge.
  task automatic lit_txn(input string nm, input logic r, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic xa, input logic [7:0] da,
                         input logic xb, input logic [7:0] db);
    if (r) chk8({nm, "_bus_b_before"}, bus_b, FLOAT);
    drive(r, w, a, d);
    @(negedge clock);
    chk1({nm, "_rdy_a_e1"}, rdy_a, 1'b0);
    chk1({nm, "_busy_a_e1"}, busy_a, 1'b1);
    chk1({nm, "_rdy_b"}, rdy_b, 1'b1);
    chk1({nm, "_err_b"}, err_b, xb);
    if (r) chk8({nm, "_bus_b"}, bus_b, xb ? FLOAT : db);
    @(negedge clock);
    chk1({nm, "_rdy_a_e2"}, rdy_a, 1'b0);
    chk1({nm, "_rdy_b_after"}, rdy_b, 1'b0);
    if (r) chk8({nm, "_bus_b_after"}, bus_b, FLOAT);
    @(negedge clock);
    chk1({nm, "_rdy_a"}, rdy_a, 1'b1);
    chk1({nm, "_err_a"}, err_a, xa);
    if (r) chk8({nm, "_bus_a"}, bus_a, xa ? FLOAT : da);
    #2 drive(1'b0, 1'b0, a, 8'h00);
    repeat (2) @(negedge clock);
    #2;
  endtask

  logic [15:0] pool [12] = '{16'h0010, 16'h0020, 16'h03FF, 16'h0400, 16'h01FF, 16'h0200,
                             16'hFE00, 16'hFDFF, 16'hFFFF, 16'h0000, 16'h0011, 16'hFE01};

  initial begin
    int pa, pb;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) @(negedge clock);
    chk1("rst_rdy_a", rdy_a, 1'b0);   chk1("rst_err_a", err_a, 1'b0);
    chk1("rst_busy_a", busy_a, 1'b0); chk8("rst_bus_a", bus_a, FLOAT);
    chk1("rst_rdy_b", rdy_b, 1'b0);   chk1("rst_busy_b", busy_b, 1'b0);
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    lit_txn("wr0010", 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    lit_txn("rd0010", 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5);
    lit_txn("wr03ff", 1'b0, 1'b1, 16'h03FF, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h00);
    lit_txn("rd03ff", 1'b1, 1'b0, 16'h03FF, 8'h00, 1'b0, 8'h5A, 1'b1, 8'h00);
    lit_txn("rd0400", 1'b1, 1'b0, 16'h0400, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
    lit_txn("wr0410", 1'b0, 1'b1, 16'h0410, 8'h77, 1'b1, 8'h00, 1'b1, 8'h00);
    lit_txn("rd0010b", 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5);
    lit_txn("wr01ff", 1'b0, 1'b1, 16'h01FF, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00);
    lit_txn("rd01ff", 1'b1, 1'b0, 16'h01FF, 8'h00, 1'b0, 8'hC3, 1'b0, 8'hC3);
    lit_txn("wr0200", 1'b0, 1'b1, 16'h0200, 8'h42, 1'b0, 8'h00, 1'b1, 8'h00);
    lit_txn("rd0200", 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 8'h42, 1'b1, 8'h00);
    lit_txn("wrfe00", 1'b0, 1'b1, 16'hFE00, 8'h5C, 1'b1, 8'h00, 1'b0, 8'h00);
    lit_txn("rdfe00", 1'b1, 1'b0, 16'hFE00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h5C);
    lit_txn("rdfdff", 1'b1, 1'b0, 16'hFDFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);

    // Both request lines high: never accepted.
    drive(1'b1, 1'b1, 16'h0050, 8'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk1("both_busy_a", busy_a, 1'b0); chk1("both_rdy_a", rdy_a, 1'b0);
      chk1("both_busy_b", busy_b, 1'b0); chk1("both_rdy_b", rdy_b, 1'b0);
    end
    #2 drive(1'b0, 1'b0, 16'h0050, 8'h00);
    @(negedge clock); #2;

    // Read held four cycles past the response: one pulse, busy until the drop.
    pa = 0; pb = 0;
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (rdy_a) pa++;
      if (rdy_b) pb++;
      chk1("held_busy_a", busy_a, 1'b1);
      chk1("held_busy_b", busy_b, 1'b1);
    end
    #2 drive(1'b0, 1'b0, 16'h0010, 8'h00);
    @(negedge clock);
    chk1("held_released_a", busy_a, 1'b0);
    chk8("held_pulses_a", 8'(pa), 8'd1);
    chk8("held_pulses_b", 8'(pb), 8'd1);
    #2;

    // Reset during a write's wait phase aborts it.
    lit_txn("wr0020", 1'b0, 1'b1, 16'h0020, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 16'h0020, 8'h3C);
    @(negedge clock);
    chk1("rstw_busy_pre", busy_a, 1'b1);
    #2 drive(1'b0, 1'b0, 16'h0020, 8'h00);
    reset = 1'b0;
    #1;
    chk1("rstw_rdy_a", rdy_a, 1'b0);   chk1("rstw_err_a", err_a, 1'b0);
    chk1("rstw_busy_a", busy_a, 1'b0); chk8("rstw_bus_a", bus_a, FLOAT);
    chk1("rstw_busy_b", busy_b, 1'b0); chk1("rstw_rdy_b", rdy_b, 1'b0);
    @(negedge clock); #2 reset = 1'b1;
    @(negedge clock); #2;
    lit_txn("rd0020", 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 8'h11, 1'b0, 8'h11);

    // Reset while the zero-wait responder drives read data releases the bus at once.
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    @(negedge clock);
    chk8("rstr_bus_b_pre", bus_b, 8'hA5);
    #2 drive(1'b0, 1'b0, 16'h0010, 8'h00);
    reset = 1'b0;
    #1;
    chk8("rstr_bus_b", bus_b, FLOAT);
    chk1("rstr_rdy_b", rdy_b, 1'b0);
    @(negedge clock); #2 reset = 1'b1;
    @(negedge clock); #2;

    // Randomized traffic with address/data perturbed after acceptance.
    for (int t = 0; t < 300; t++) begin
      int kind, hold, gap;
      logic [15:0] a;
      kind = $urandom_range(0, 9);
      a    = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 11)] : 16'($urandom);
      drive(kind < 4, kind >= 4, a, 8'($urandom));
      if (kind == 9) mem_read = 1'b1;
      hold = $urandom_range(4, 7);
      for (int j = 1; j < hold; j++) begin
        @(negedge clock); #2;
        address = 16'($urandom);
        tb_val  = 8'($urandom);
      end
      @(negedge clock); #2 drive(1'b0, 1'b0, address, 8'h00);
      gap = $urandom_range(1, 3);
      repeat (gap) @(negedge clock);
      #2;
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
